passcode_checker: RTL and testbench

//  Keypad entry / verification FSM for the door lock; consumes digits from display_reg.

---
 rtl/passcode_checker.sv | 252 +++++++++++++++++++++++++
 tb/tb_passcode_checker.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_checker.sv
// -----------------------------------------------------------------------------
// passcode_checker
//   Keypad entry / verification FSM for the door lock. The physical key index
//   is forwarded combinationally to display_reg (button_index), which returns
//   the digit currently shown on that key (digit_in) in the same cycle.
//   CODE_LEN digits are buffered; ENTER compares them against the stored code.
//   A match opens the door for UNLOCK_CYCLES; a miss pulses attempt_fail, and
//   MAX_FAIL consecutive misses lock the keypad for LOCKOUT_CYCLES. Every
//   attempt requests a keypad reshuffle through shuffle_init.
//
//   Optional feature macro: PASSCODE_CHANGE_EN
//     defined   : SET while open enters PROGRAM, where a new code is entered
//                 and committed with ENTER.
//     undefined : code is the constant DEFAULT_CODE, SET is ignored.
//
// Ports
//   clk          in   clock
//   rstn         in   asynchronous active-low reset
//   key_valid    in   one-cycle key-press strobe
//   key_index    in   [3:0] 0-9 digit keys, 10 ENTER, 11 CLEAR, 12 SET
//   button_index out  [3:0] combinational copy of key_index
//   digit_in     in   [3:0] digit shown on button_index
//   shuffle_init out  one-cycle reshuffle request
//   unlock       out  door open
//   locked_out   out  lockout active
//   attempt_fail out  one-cycle pulse per rejected attempt
//   digit_count  out  [3:0] digits currently buffered
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module passcode_checker #(
  parameter int unsigned               CODE_LEN       = 4,
  parameter int unsigned               MAX_FAIL       = 3,
  parameter int unsigned               UNLOCK_CYCLES  = 100,
  parameter int unsigned               LOCKOUT_CYCLES = 1000,
  parameter logic [4*CODE_LEN-1:0]     DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_valid,
  input  logic [3:0] key_index,
  output logic [3:0] button_index,
  input  logic [3:0] digit_in,
  output logic       shuffle_init,
  output logic       unlock,
  output logic       locked_out,
  output logic       attempt_fail,
  output logic [3:0] digit_count
);

  localparam int unsigned CW = 4 * CODE_LEN;
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned TW = 32;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
`ifdef PASSCODE_CHANGE_EN
  localparam logic [3:0] KEY_SET   = 4'd12;
`endif

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3
`ifdef PASSCODE_CHANGE_EN
    ,ST_PROGRAM = 3'd4
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   buffer_q, buffer_d;
  logic [3:0]      count_q, count_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            shuffle_q, shuffle_d;
  logic            unlock_q, unlock_d;
  logic            locked_q, locked_d;
  logic            afail_q, afail_d;
  logic [CW-1:0]   code;

  // Key decode, qualified by the strobe
  logic key_digit_c, key_enter_c, key_clear_c, buf_full_c, match_c, last_fail_c;
  assign key_digit_c = key_valid && (key_index <= 4'd9);
  assign key_enter_c = key_valid && (key_index == KEY_ENTER);
  assign key_clear_c = key_valid && (key_index == KEY_CLEAR);
  assign buf_full_c  = (count_q == 4'(CODE_LEN));
  assign match_c     = buf_full_c && (buffer_q == code);
  assign last_fail_c = ((TW'(fail_q) + 32'd1) == TW'(MAX_FAIL));

`ifdef PASSCODE_CHANGE_EN
  logic [CW-1:0] code_q, code_d;
  logic          key_set_c;
  assign key_set_c = key_valid && (key_index == KEY_SET);
  assign code      = code_q;
`else
  assign code      = DEFAULT_CODE;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_ENTRY;
      buffer_q  <= '0;
      count_q   <= '0;
      fail_q    <= '0;
      timer_q   <= '0;
      shuffle_q <= 1'b0;
      unlock_q  <= 1'b0;
      locked_q  <= 1'b0;
      afail_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buffer_q  <= buffer_d;
      count_q   <= count_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      shuffle_q <= shuffle_d;
      unlock_q  <= unlock_d;
      locked_q  <= locked_d;
      afail_q   <= afail_d;
    end
  end

`ifdef PASSCODE_CHANGE_EN
  // Stored code, rewritable from PROGRAM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_q <= DEFAULT_CODE;
    end else begin
      code_q <= code_d;
    end
  end
`endif

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    buffer_d  = buffer_q;
    count_d   = count_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    shuffle_d = 1'b0;
    afail_d   = 1'b0;
`ifdef PASSCODE_CHANGE_EN
    code_d    = code_q;
`endif

    case (state_q)
      ST_ENTRY: begin
        // Digits beyond CODE_LEN are dropped rather than shifting older ones out
        if (key_digit_c) begin
          if (!buf_full_c) begin
            buffer_d = CW'({buffer_q, digit_in});
            count_d  = count_q + 4'd1;
          end
        end else if (key_clear_c) begin
          buffer_d = '0;
          count_d  = '0;
        end else if (key_enter_c) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        shuffle_d = 1'b1;
        buffer_d  = '0;
        count_d   = '0;
        if (match_c) begin
          fail_d  = '0;
          timer_d = TW'(UNLOCK_CYCLES - 1);
          state_d = ST_OPEN;
        end else begin
          afail_d = 1'b1;
          if (last_fail_c) begin
            fail_d  = '0;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
            state_d = ST_LOCKOUT;
          end else begin
            fail_d  = fail_q + FW'(1);
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
`ifdef PASSCODE_CHANGE_EN
        // SET takes priority over the open-time expiring in the same cycle
        if (key_set_c) begin
          buffer_d = '0;
          count_d  = '0;
          timer_d  = '0;
          state_d  = ST_PROGRAM;
        end else
`endif
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

`ifdef PASSCODE_CHANGE_EN
      ST_PROGRAM: begin
        if (key_digit_c) begin
          if (!buf_full_c) begin
            buffer_d = CW'({buffer_q, digit_in});
            count_d  = count_q + 4'd1;
          end
        end else if (key_clear_c) begin
          buffer_d = '0;
          count_d  = '0;
          state_d  = ST_ENTRY;
        end else if (key_enter_c && buf_full_c) begin
          code_d    = buffer_q;
          shuffle_d = 1'b1;
          buffer_d  = '0;
          count_d   = '0;
          state_d   = ST_ENTRY;
        end
      end
`endif

      default: begin
        state_d  = ST_ENTRY;
        buffer_d = '0;
        count_d  = '0;
        timer_d  = '0;
      end
    endcase

    // Level outputs follow the state being entered, so they align with it
    unlock_d = (state_d == ST_OPEN);
    locked_d = (state_d == ST_LOCKOUT);
  end

  assign button_index = key_index;
  assign shuffle_init = shuffle_q;
  assign unlock       = unlock_q;
  assign locked_out   = locked_q;
  assign attempt_fail = afail_q;
  assign digit_count  = count_q;

endmodule

// File: tb/tb_passcode_checker.sv
// -----------------------------------------------------------------------------
// tb_passcode_checker
//   Self-checking bench for passcode_checker: a table of hand-computed vectors,
//   hand-written multi-cycle sequences (lockout, fail counter reset, async
//   reset, optional code change) and randomized attempts, all checked every
//   cycle against an attempt-level reference model built from queues and
//   remaining-time counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_passcode_checker;

  localparam int unsigned CODE_LEN       = 4;
  localparam int unsigned MAX_FAIL       = 3;
  localparam int unsigned UNLOCK_CYCLES  = 100;
  localparam int unsigned LOCKOUT_CYCLES = 1000;
  localparam logic [15:0] DEF_CODE       = 16'h1234;

  localparam logic [3:0] K_ENTER = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [3:0] K_SET   = 4'd12;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_valid;
  logic [3:0] key_index;
  logic [3:0] button_index;
  logic [3:0] digit_in;
  logic       shuffle_init;
  logic       unlock;
  logic       locked_out;
  logic       attempt_fail;
  logic [3:0] digit_count;

  always #5 clk = ~clk;

  passcode_checker #(
    .CODE_LEN      (CODE_LEN),
    .MAX_FAIL      (MAX_FAIL),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .DEFAULT_CODE  (DEF_CODE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_valid   (key_valid),
    .key_index   (key_index),
    .button_index(button_index),
    .digit_in    (digit_in),
    .shuffle_init(shuffle_init),
    .unlock      (unlock),
    .locked_out  (locked_out),
    .attempt_fail(attempt_fail),
    .digit_count (digit_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffered digits, stored code, remaining open/lockout time
  int          q_dig[$];
  int          m_fails;
  logic [15:0] m_code;
  int          m_open_left;
  int          m_lock_left;
  bit          m_check;
  bit          m_prog;
  bit          e_shuf;
  bit          e_fail;

  // Observed-behaviour counters for the multi-cycle sequences
  int c_unlock, c_lock, c_shuf, c_fail, c_maxcnt;

  typedef struct {
    logic       v;
    logic [3:0] idx;
    logic [3:0] dig;
    logic       unl;
    logic       shf;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] q_value();
    logic [15:0] v = '0;
    foreach (q_dig[i]) v = {v[11:0], 4'(q_dig[i])};
    return v;
  endfunction

  task automatic model_reset();
    q_dig.delete();
    m_fails = 0;
    m_code = DEF_CODE;
    m_open_left = 0;
    m_lock_left = 0;
    m_check = 0;
    m_prog = 0;
    e_shuf = 0;
    e_fail = 0;
  endtask

  task automatic clear_counters();
    c_unlock = 0; c_lock = 0; c_shuf = 0; c_fail = 0; c_maxcnt = 0;
  endtask

  // Advance the model by one clock edge with the given key inputs
  task automatic model_edge(input logic v, input logic [3:0] idx, input logic [3:0] dig);
    bit match;
    e_shuf = 0;
    e_fail = 0;
    if (m_check) begin
      m_check = 0;
      e_shuf = 1;
      match = (q_dig.size() == CODE_LEN) && (q_value() == m_code);
      q_dig.delete();
      if (match) begin
        m_fails = 0;
        m_open_left = UNLOCK_CYCLES;
      end else begin
        e_fail = 1;
        if (m_fails + 1 == MAX_FAIL) begin
          m_fails = 0;
          m_lock_left = LOCKOUT_CYCLES;
        end else begin
          m_fails++;
        end
      end
    end else if (m_open_left > 0) begin
`ifdef PASSCODE_CHANGE_EN
      if (v && idx == K_SET) begin
        m_open_left = 0;
        m_prog = 1;
        q_dig.delete();
      end else
`endif
      m_open_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (v) begin
      if (idx <= 4'd9) begin
        if (q_dig.size() < CODE_LEN) q_dig.push_back(int'(dig));
      end else if (idx == K_CLEAR) begin
        q_dig.delete();
        m_prog = 0;
      end else if (idx == K_ENTER) begin
        if (!m_prog) begin
          m_check = 1;
        end else if (q_dig.size() == CODE_LEN) begin
          m_code = q_value();
          e_shuf = 1;
          q_dig.delete();
          m_prog = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, check the combinational path, then the edge result
  task automatic cycle(input logic v, input logic [3:0] idx, input logic [3:0] dig);
    logic [7:0] act, exp;
    key_valid = v;
    key_index = idx;
    digit_in  = dig;
    #1;
    check("button_index", 32'(button_index), 32'(idx));
    model_edge(v, idx, dig);
    @(posedge clk);
    #1;
    exp = {m_open_left > 0, m_lock_left > 0, e_shuf, e_fail, 4'(q_dig.size())};
    act = {unlock, locked_out, shuffle_init, attempt_fail, digit_count};
    check("outputs{unl,lck,shf,afl,cnt}", 32'(act), 32'(exp));
    c_unlock += int'(unlock);
    c_lock   += int'(locked_out);
    c_shuf   += int'(shuffle_init);
    c_fail   += int'(attempt_fail);
    if (locked_out && int'(digit_count) > c_maxcnt) c_maxcnt = int'(digit_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0);
  endtask

  // Enter n digits of a code (key index equals the digit shown), then ENTER
  task automatic attempt(input logic [15:0] code, input int n);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = code[15 - 4*i -: 4];
      cycle(1'b1, d, d);
    end
    cycle(1'b1, K_ENTER, 4'd0);
    idle(2);
  endtask

  task automatic random_press();
    logic [3:0] k;
    if ($urandom_range(0, 7) == 0) begin
      k = 4'($urandom_range(0, 15));
      cycle(1'b1, k, 4'($urandom_range(0, 9)));
    end else begin
      cycle(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)));
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'd9,  4'd9, 1'b0, 1'b0, 4'd1};
    tbl[1]  = '{1'b1, 4'd9,  4'd9, 1'b0, 1'b0, 4'd2};
    tbl[2]  = '{1'b1, K_CLEAR, 4'd0, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 4'd3,  4'd1, 1'b0, 1'b0, 4'd1};
    tbl[4]  = '{1'b1, 4'd7,  4'd2, 1'b0, 1'b0, 4'd2};
    tbl[5]  = '{1'b1, 4'd0,  4'd3, 1'b0, 1'b0, 4'd3};
    tbl[6]  = '{1'b1, 4'd5,  4'd4, 1'b0, 1'b0, 4'd4};
    tbl[7]  = '{1'b1, 4'd1,  4'd7, 1'b0, 1'b0, 4'd4};
    tbl[8]  = '{1'b1, K_SET, 4'd0, 1'b0, 1'b0, 4'd4};
    tbl[9]  = '{1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 4'd4};
    tbl[10] = '{1'b0, 4'd2,  4'd5, 1'b0, 1'b0, 4'd4};
    tbl[11] = '{1'b1, K_ENTER, 4'd0, 1'b0, 1'b0, 4'd4};
    tbl[12] = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 4'd0};
    tbl[13] = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 4'd0};

    rstn = 1'b0;
    key_valid = 1'b0;
    key_index = 4'd0;
    digit_in = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({unlock, locked_out, shuffle_init, attempt_fail, digit_count}), 32'd0);
    rstn = 1'b1;

    // Table: CLEAR, overflow digit, ignored keys, then correct code opens
    clear_counters();
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].idx, tbl[i].dig);
      check($sformatf("tbl[%0d]{unl,shf,cnt}", i),
            32'({unlock, shuffle_init, digit_count}),
            32'({tbl[i].unl, tbl[i].shf, tbl[i].cnt}));
    end
    idle(110);
    check("open_unlock_cycles", 32'(c_unlock), 32'(UNLOCK_CYCLES));
    check("open_shuffle_pulses", 32'(c_shuf), 32'd1);
    check("open_attempt_fail", 32'(c_fail), 32'd0);

    // Three wrong codes lock out; keys during lockout do nothing
    clear_counters();
    for (int a = 0; a < 3; a++) attempt(16'h1235, 4);
    for (int i = 0; i < 990; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)));
    idle(20);
    check("lock_fail_pulses", 32'(c_fail), 32'd3);
    check("lock_shuffle_pulses", 32'(c_shuf), 32'd3);
    check("lock_cycles", 32'(c_lock), 32'(LOCKOUT_CYCLES));
    check("lock_max_digit_count", 32'(c_maxcnt), 32'd0);
    check("lock_unlock_cycles", 32'(c_unlock), 32'd0);

    // Success resets the failure count
    clear_counters();
    attempt(16'h1235, 4);
    attempt(16'h0000, 2);
    attempt(DEF_CODE, 4);
    idle(100);
    attempt(16'h9999, 4);
    attempt(16'h1234, 3);
    check("failreset_unlock_cycles", 32'(c_unlock), 32'(UNLOCK_CYCLES));
    check("failreset_fail_pulses", 32'(c_fail), 32'd4);
    check("failreset_no_lockout", 32'(c_lock), 32'd0);

    // Asynchronous reset in the middle of the open period
    cycle(1'b1, K_CLEAR, 4'd0);
    attempt(DEF_CODE, 4);
    idle(48);
    check("pre_reset_unlock", 32'(unlock), 32'd1);
    rstn = 1'b0;
    #1;
    check("async_reset_drops", 32'({unlock, locked_out, digit_count}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    attempt(DEF_CODE, 4);
    check("post_reset_default_code", 32'(unlock), 32'd1);
    idle(100);

    // Randomized attempts against the model
    for (int a = 0; a < 25; a++) begin
      int nd;
      bit good;
      int guard;
      logic [3:0] d;
      nd = $urandom_range(0, 6);
      good = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < nd; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          cycle(1'b1, 4'($urandom_range(11, 15)), 4'd0);
        end
        if (good && i < 4) d = m_code[15 - 4*i -: 4];
        else d = 4'($urandom_range(0, 9));
        cycle(1'b1, 4'($urandom_range(0, 9)), d);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      cycle(1'b1, K_ENTER, 4'd0);
      for (int i = 0; i < int'($urandom_range(2, 120)); i++) random_press();
      guard = 0;
      while ((m_open_left > 0 || m_lock_left > 0 || m_check) && guard < 2000) begin
        random_press();
        guard++;
      end
      if (guard >= 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL random_settle: model busy after %0d cycles, expected idle", guard);
      end
    end

`ifdef PASSCODE_CHANGE_EN
    // Change the code from the open state, then only the new code opens
    rstn = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    attempt(DEF_CODE, 4);
    idle(3);
    cycle(1'b1, K_SET, 4'd0);
    check("set_drops_unlock", 32'(unlock), 32'd0);
    clear_counters();
    attempt(16'h5678, 4);
    check("program_commit_shuffle", 32'(c_shuf), 32'd1);
    check("program_no_unlock", 32'(c_unlock), 32'd0);
    clear_counters();
    attempt(DEF_CODE, 4);
    check("old_code_rejected", 32'(c_fail), 32'd1);
    attempt(16'h5678, 4);
    check("new_code_unlocks", 32'(unlock), 32'd1);
    idle(100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
